// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared encodings for the unified memory arbiter: FSM
//                states and transaction-owner codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/starve_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : starve_arbiter
//  Description : Two-way priority select between fetch and data requests.
//                Data wins by default. Fetch wins when data is idle, or once
//                it has watched STARVE_LIMIT consecutive data grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module starve_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic fetch_valid,
    input  logic data_valid,
    output logic grant_fetch,
    output logic grant_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grant decision, only while the owning FSM is idle and able to accept
    always_comb begin
        grant_fetch = arb_en && fetch_valid && (!data_valid || starved);
        grant_data  = arb_en && data_valid && !grant_fetch;
    end

    // Count data grants that overtook a waiting fetch; fetch grant or an idle
    // fetch port resets the count. Only arbitration cycles update it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (grant_fetch || !fetch_valid) begin
                starve_cnt <= '0;
            end else if (grant_data) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule : starve_arbiter
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Shares one single-port memory between the instruction-fetch
//                and data ports. One transaction outstanding at a time;
//                responses are routed back to the requester, and fetch
//                responses can be discarded by a branch-redirect flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch port
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_flush,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    // data port
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    // backing memory port
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic              m_req_we,
    output logic [DATA_W-1:0] m_req_wdata,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_data
);

    state_t state;
    owner_t owner;
    logic   flush_pending;
    logic   arb_en;
    logic   grant_fetch;
    logic   grant_data;

    // Arbitrate only when idle; holding off during reset keeps the ready
    // outputs low while reset is asserted even with requests present.
    assign arb_en = (state == ST_IDLE) && !reset;

    starve_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_arbiter (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (arb_en),
        .fetch_valid (i_req_valid),
        .data_valid  (d_req_valid),
        .grant_fetch (grant_fetch),
        .grant_data  (grant_data)
    );

    // Request acceptance is the grant itself, same cycle
    always_comb begin
        i_req_ready = grant_fetch;
        d_req_ready = grant_data;
        m_req_valid = (state == ST_ISSUE);
    end

    // Transaction sequencer: latch the winner, hand it to memory, wait for
    // the response and deliver it as a one-cycle pulse to the owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= OWN_NONE;
            flush_pending <= 1'b0;
            m_req_addr    <= '0;
            m_req_we      <= 1'b0;
            m_req_wdata   <= '0;
            i_resp_valid  <= 1'b0;
            i_resp_data   <= '0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
        end else begin
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        m_req_addr    <= d_req_addr;
                        m_req_we      <= d_req_we;
                        m_req_wdata   <= d_req_wdata;
                        owner         <= OWN_DATA;
                        flush_pending <= 1'b0;
                        state         <= ST_ISSUE;
                    end else if (grant_fetch) begin
                        m_req_addr    <= i_req_addr;
                        m_req_we      <= 1'b0;
                        m_req_wdata   <= '0;
                        owner         <= OWN_FETCH;
                        flush_pending <= 1'b0;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if ((owner == OWN_FETCH) && i_flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (m_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if ((owner == OWN_FETCH) && i_flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (m_resp_valid) begin
                        if (owner == OWN_FETCH) begin
                            // A redirect seen at any point, including this
                            // very cycle, means the instruction is stale.
                            if (!(flush_pending || i_flush)) begin
                                i_resp_data  <= m_resp_data;
                                i_resp_valid <= 1'b1;
                            end
                        end else begin
                            d_resp_data  <= m_resp_data;
                            d_resp_valid <= 1'b1;
                        end
                        owner <= OWN_NONE;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : unified_mem_arbiter
`default_nettype wire
